// File: rtl/mux_arbiter2.sv
// mux_arbiter2: two-requester round-robin arbiter owning a registered 2:1 data mux.
// Define ARB_TIMEOUT_EN to add a grant timer that forces a release after TIMEOUT cycles.
module mux_arbiter2 #(
  parameter int w       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         done0,
  input  logic         done1,
  input  logic [w-1:0] data_in_0,
  input  logic [w-1:0] data_in_1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         selector,
  output logic [w-1:0] data_out,
  output logic         valid_out,
  output logic         timeout
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, sel_q, sel_d, valid_q, timeout_q, timeout_d;
  logic [w-1:0] data_q;
  logic own, own1, req_x, req_o, done_x, rel, force_rel;
  assign own    = state_q != IDLE;
  assign own1   = state_q == OWN1;
  assign req_x  = own1 ? req1 : req0;
  assign req_o  = own1 ? req0 : req1;
  assign done_x = own1 ? done1 : done0;
  assign rel    = own & (done_x | ~req_x);
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic cnt_top;
  assign cnt_top   = cnt_q == 8'(TIMEOUT - 1);
  assign force_rel = own & ~rel & req_o & cnt_top;
  // Restart on every grant entry; saturate at the limit while nobody is waiting.
  assign cnt_d = (!own || rel || force_rel) ? 8'd0 : cnt_top ? cnt_q : cnt_q + 8'd1;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
`else
  localparam int timeout_unused = TIMEOUT;
  assign force_rel = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    if (!own) begin
      if (req0 & req1) state_d = last_q ? OWN0 : OWN1;
      else if (req0) state_d = OWN0;
      else if (req1) state_d = OWN1;
    end else if (rel | force_rel) begin
      last_d    = own1;
      timeout_d = force_rel;
      state_d   = req_o ? (own1 ? OWN0 : OWN1) : (req_x & done_x) ? state_q : IDLE;
    end
    sel_d = state_d == OWN1 ? 1'b1 : state_d == OWN0 ? 1'b0 : sel_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      valid_q   <= own;
      timeout_q <= timeout_d;
      if (own) data_q <= own1 ? data_in_1 : data_in_0;
    end
  end
  assign gnt0      = state_q == OWN0;
  assign gnt1      = own1;
  assign selector  = sel_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_mux_arbiter2.sv
// tb_mux_arbiter2: directed self-checking bench for mux_arbiter2.
module tb_mux_arbiter2;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
  logic [31:0] data_in_0 = '0, data_in_1 = '0, data_out;
  logic gnt0, gnt1, selector, valid_out, timeout;
  int n_chk = 0, n_pass = 0;
  mux_arbiter2 #(.w(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .done0(done0), .done1(done1),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .gnt0(gnt0), .gnt1(gnt1),
    .selector(selector), .data_out(data_out), .valid_out(valid_out), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_sel", selector, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    req0 = 1'b1;
    data_in_0 = 32'hA5A5A5A5;
    step();
    check("t1_gnt0", gnt0, 1);
    check("t1_sel", selector, 0);
    check("t1_valid_early", valid_out, 0);
    step();
    check("t1_data", data_out, 32'hA5A5A5A5);
    check("t1_valid", valid_out, 1);
    req0 = 1'b0;
    step();
    check("t1_rel_gnt0", gnt0, 0);
    check("t1_rel_valid", valid_out, 1);
    step();
    check("t1_idle_valid", valid_out, 0);
    check("t1_idle_data", data_out, 32'hA5A5A5A5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    data_in_0 = 32'h11111111;
    data_in_1 = 32'h22222222;
    step();
    check("t2_tie_gnt0", gnt0, 1);
    check("t2_tie_gnt1", gnt1, 0);
    done0 = 1'b1;
    step();
    done0 = 1'b0;
    check("t2_hand_gnt1", gnt1, 1);
    check("t2_hand_gnt0", gnt0, 0);
    check("t2_hand_sel", selector, 1);
    check("t2_hand_data", data_out, 32'h11111111);
    step();
    check("t2_own1_data", data_out, 32'h22222222);
    check("t2_own1_valid", valid_out, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check("t2_idle_gnt1", gnt1, 0);
    req0 = 1'b1;
    req1 = 1'b1;
    step();
    check("t2_alt_gnt0", gnt0, 1);
    check("t2_alt_gnt1", gnt1, 0);
    req0 = 1'b0;
    done0 = 1'b1;
    data_in_1 = 32'h33333333;
    step();
    check("t3_own1", gnt1, 1);
    step();
    check("t3_done0_ign", gnt1, 1);
    check("t3_done0_gnt0", gnt0, 0);
    done0 = 1'b0;
    req1 = 1'b0;
    step();
    check("t3_idle_gnt1", gnt1, 0);
    step();
    check("t3_idle_valid", valid_out, 0);
    check("t3_idle_sel", selector, 1);
    check("t3_idle_data", data_out, 32'h33333333);
    req1 = 1'b1;
    step();
    step();
    for (int i = 0; i < 12; i++) begin
      done1 = (i % 4 == 3);
      data_in_1 = 32'(i + 100);
      step();
      check($sformatf("t4_gnt1_%0d", i), gnt1, 1);
      check($sformatf("t4_valid_%0d", i), valid_out, 1);
      check($sformatf("t4_data_%0d", i), data_out, 32'(i + 100));
    end
    done1 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    req0 = 1'b1;
    data_in_0 = 32'hDEADBEEF;
    step();
    step();
    check("t5_flow", data_out, 32'hDEADBEEF);
    req1 = 1'b1;
    reset = 1'b1;
    step();
    check("t5_rst_gnt0", gnt0, 0);
    check("t5_rst_data", data_out, 0);
    check("t5_rst_valid", valid_out, 0);
    reset = 1'b0;
    step();
    check("t5_tie_gnt0", gnt0, 1);
    check("t5_tie_gnt1", gnt1, 0);
    check("t5_no_timeout", timeout, 0);
`ifdef ARB_TIMEOUT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("t6_c1", gnt0, 1);
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("t6_c%0d_gnt0", i), gnt0, 1);
      check($sformatf("t6_c%0d_tmo", i), timeout, 0);
    end
    step();
    check("t6_sw_gnt0", gnt0, 0);
    check("t6_sw_gnt1", gnt1, 1);
    check("t6_sw_tmo", timeout, 1);
    step();
    check("t6_tmo_pulse", timeout, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
